multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst  in  1  asynchronous active-low reset (0 = reset).
REQ-003 SHALL have ports: opcode  in  7  instruction opcode field, read from the instruction register.
REQ-004 SHALL have ports: funct3  in  3  branch condition selector.
REQ-005 SHALL have ports: zero, neg  in  1 each  ALU result flags for the current cycle.
REQ-006 SHALL have ports: PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc  out  1 each.
REQ-007 SHALL have ports: ResultSrc, ALUSrcA, ALUSrcB, ALUOp  out  2 each.
REQ-008 SHALL have ports: ImmSrc  out  3.
REQ-009 SHALL use these select encodings:
- AdrSrc: 0 PC, 1 Result.
- ALUSrcA: 00 PC, 01 OldPC, 10 RegA.
- ALUSrcB: 00 RegB, 01 ImmExt, 10 constant 4.
- ResultSrc: 00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt.
- ALUOp: 00 add, 01 compare/sub, 10 R-funct, 11 I-funct.

Function
REQ-010 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR1, JALR2, LUI; PCWrite in BRANCH is the only Mealy term.
REQ-011 SHALL drive every output not listed for a state to 0, except ImmSrc.
REQ-012 SHALL drive ImmSrc combinationally from opcode in all states: 000 for R/I/LW/JALR, 001 for S, 010 for B, 011 for J, 100 for U, and 000 for unknown opcodes.
REQ-013 FETCH SHALL drive AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCWrite=1, then go to DECODE.
REQ-014 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target into ALUOut), then go to:
- MEMADR on LW (0000011) or S (0100011);
- EXECR on 0110011; EXECI on 0010011;
- BRANCH on 1100011; JAL on 1101111; JALR1 on 1100111; LUI on 0110111;
- FETCH on any other opcode.
REQ-015 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00, then go to MEMREAD if LW, else MEMWRITE.
REQ-016 MEMREAD SHALL drive ResultSrc=00, AdrSrc=1, then go to MEMWB.
REQ-017 MEMWB SHALL drive ResultSrc=01, RegWrite=1, then go to FETCH.
REQ-018 MEMWRITE SHALL drive ResultSrc=00, AdrSrc=1, MemWrite=1, then go to FETCH.
REQ-019 EXECR SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10, then go to ALUWB.
REQ-020 EXECI SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=11, then go to ALUWB.
REQ-021 ALUWB SHALL drive ResultSrc=00, RegWrite=1, then go to FETCH.
REQ-022 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, and PCWrite=taken, then go to FETCH. taken is:
- funct3 000: zero; 001: !zero; 100: neg; 101: !neg;
- any other funct3: 0 (not taken).
REQ-023 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then go to ALUWB.
REQ-024 JALR1 SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00, then go to JALR2.
REQ-025 JALR2 SHALL drive ResultSrc=00, PCWrite=1, ALUSrcA=01, ALUSrcB=10, ALUOp=00, then go to ALUWB.
REQ-026 LUI SHALL drive ResultSrc=11, RegWrite=1, then go to FETCH.
REQ-027 SHALL take these cycles per instruction, FETCH inclusive:
- LW 5, JALR 5;
- SW 4, R 4, I 4, JAL 4;
- B 3, LUI 3;
- unknown opcode 2.
REQ-028 SHALL never assert RegWrite and MemWrite in the same cycle, and SHALL assert IRWrite only in FETCH.

Reset
REQ-029 rst=0 SHALL force state to FETCH immediately, including mid-instruction; pending writes are abandoned.
REQ-030 While rst=0, all write enables (PCWrite, IRWrite, MemWrite, RegWrite) SHALL be 0.
REQ-031 The first rising clk edge after rst deasserts SHALL complete a FETCH.

Structure
REQ-032 Opcode constants, state encoding and select encodings SHALL live in a shared header used by the datapath and this controller.
REQ-033 Branch condition logic SHALL be a sub-module branch_cond (funct3, zero, neg -> taken).

Verification
REQ-034 LW opcode 0000011 after reset -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 with ResultSrc=01 only in cycle 5.
REQ-035 BEQ (1100011, funct3 000): zero=1 -> PCWrite=1 in cycle 3; zero=0 -> PCWrite=0; funct3 010 -> PCWrite=0.
REQ-036 JALR (1100111) -> PCWrite=1 in cycles 1 and 4, RegWrite=1 in cycle 5 with ResultSrc=00.
REQ-037 Opcode 1111111 -> DECODE returns to FETCH, and no write enable asserts besides PCWrite/IRWrite in FETCH.
REQ-038 rst=0 pulsed during MEMWRITE -> MemWrite drops immediately, and FETCH follows deassertion.
REQ-039 SW (0100011) -> MemWrite=1 exactly once, in cycle 4, with AdrSrc=1 and ImmSrc=001 throughout.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared opcode constants, controller state encoding and datapath select encodings
// for the multicycle core; imported by both the controller and the datapath.
package multicycle_controller_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2, S_LUI
    } state_t;

    localparam logic       ADR_PC        = 1'b0;
    localparam logic       ADR_RESULT    = 1'b1;

    localparam logic [1:0] SRCA_PC       = 2'b00;
    localparam logic [1:0] SRCA_OLDPC    = 2'b01;
    localparam logic [1:0] SRCA_REGA     = 2'b10;

    localparam logic [1:0] SRCB_REGB     = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMM       = 2'b11;

    localparam logic [1:0] ALUOP_ADD     = 2'b00;
    localparam logic [1:0] ALUOP_SUB     = 2'b01;
    localparam logic [1:0] ALUOP_RFUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_IFUNCT  = 2'b11;

    localparam logic [2:0] IMM_I         = 3'b000;
    localparam logic [2:0] IMM_S         = 3'b001;
    localparam logic [2:0] IMM_B         = 3'b010;
    localparam logic [2:0] IMM_J         = 3'b011;
    localparam logic [2:0] IMM_U         = 3'b100;

    // Immediate format depends only on the opcode; unknown opcodes fall back to I-type.
    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_B:    return IMM_B;
            OP_JAL:  return IMM_J;
            OP_LUI:  return IMM_U;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_branch_cond.sv
// Branch condition evaluation: decides whether a conditional branch is taken
// from funct3 and the ALU compare flags.
module branch_cond
    import multicycle_controller_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       neg,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = neg;
            3'b101:  taken = ~neg;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style main controller: Moore FSM sequencing fetch, decode and
// per-class execute steps; only the branch PC write depends on the live ALU flags.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       neg,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc
);

    state_t state_reg;
    state_t state_next;
    logic   taken;
    logic   pc_write;
    logic   ir_write;
    logic   mem_write;
    logic   reg_write;

    branch_cond u_branch_cond (
        .funct3 (funct3),
        .zero   (zero),
        .neg    (neg),
        .taken  (taken)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        AdrSrc     = ADR_PC;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_REGB;
        ALUOp      = ALUOP_ADD;
        case (state_reg)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_I:         state_next = S_EXECI;
                    OP_B:         state_next = S_BRANCH;
                    OP_JAL:       state_next = S_JAL;
                    OP_JALR:      state_next = S_JALR1;
                    OP_LUI:       state_next = S_LUI;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_REGA;
                ALUSrcB    = SRCB_IMM;
                state_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc     = ADR_RESULT;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = ADR_RESULT;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_REGA;
                ALUOp      = ALUOP_RFUNCT;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_REGA;
                ALUSrcB    = SRCB_IMM;
                ALUOp      = ALUOP_IFUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = SRCA_REGA;
                ALUOp    = ALUOP_SUB;
                pc_write = taken;
            end
            S_JAL: begin
                // ALUOut already holds the jump target from DECODE; compute PC+4 for rd.
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
            S_JALR1: begin
                ALUSrcA    = SRCA_REGA;
                ALUSrcB    = SRCB_IMM;
                state_next = S_JALR2;
            end
            S_JALR2: begin
                pc_write   = 1'b1;
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                state_next = S_ALUWB;
            end
            S_LUI: begin
                ResultSrc = RES_IMM;
                reg_write = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Write enables are forced low while reset is held, even though the state is FETCH.
    assign PCWrite  = rst & pc_write;
    assign IRWrite  = rst & ir_write;
    assign MemWrite = rst & mem_write;
    assign RegWrite = rst & reg_write;
    assign ImmSrc   = imm_sel(opcode);

endmodule
